// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: saturating ADD/SUB, XOR, RED, PADDSB, and 1-bit/cycle SLL/SRA/ROR.
// Owns the {Z,V,N} flag register, which is written on the edge that loads a result into DONE.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// SHIFT | iterating a shift/rotate one bit per cycle, in_ready=0
// DONE  | result held on result/out_valid until out_ready
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         flags
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_RED    = 3'b011;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;
    localparam logic [2:0] OP_PADDSB = 3'b111;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;

    logic               accept;
    logic               is_shift;
    logic [WIDTH:0]     add_ext;
    logic               add_ovf;
    logic [WIDTH-1:0]   add_sat;
    logic [WIDTH-1:0]   red_acc;
    logic [4:0]         lane_sum;
    logic [WIDTH-1:0]   psb_res;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   shift_nxt;

    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);
    assign is_shift  = (op == OP_SLL) | (op == OP_SRA) | (op == OP_ROR);

    // One extra bit of headroom: overflow shows as disagreement of the top two bits.
    always_comb begin
        add_ext = (op == OP_SUB) ? ({a[WIDTH-1], a} - {b[WIDTH-1], b})
                                 : ({a[WIDTH-1], a} + {b[WIDTH-1], b});
        add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
        add_sat = add_ovf ? (add_ext[WIDTH] ? SAT_MIN : SAT_MAX) : add_ext[WIDTH-1:0];
    end

    always_comb begin
        red_acc = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            red_acc = red_acc + WIDTH'($signed(a[8*i +: 8])) + WIDTH'($signed(b[8*i +: 8]));
        end
    end

    always_comb begin
        psb_res  = '0;
        lane_sum = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            lane_sum = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
            if (lane_sum[4] != lane_sum[3])
                psb_res[4*i +: 4] = lane_sum[4] ? 4'h8 : 4'h7;
            else
                psb_res[4*i +: 4] = lane_sum[3:0];
        end
    end

    // Shift ops only reach this mux with shamt==0, where the result is a unchanged.
    always_comb begin
        case (op)
            OP_ADD, OP_SUB: alu_res = add_sat;
            OP_XOR:         alu_res = a ^ b;
            OP_RED:         alu_res = red_acc;
            OP_PADDSB:      alu_res = psb_res;
            default:        alu_res = a;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shift_nxt = {work[WIDTH-2:0], 1'b0};
            OP_SRA:  shift_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_ROR:  shift_nxt = {work[0], work[WIDTH-1:1]};
            default: shift_nxt = work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            result <= '0;
            flags  <= 3'b000;
            work   <= '0;
            cnt    <= '0;
            op_q   <= '0;
        end else begin
            case (state)
                S_SHIFT: begin
                    work <= shift_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result   <= shift_nxt;
                        flags[2] <= (shift_nxt == '0);
                        state    <= S_DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        op_q <= op;
                        if (is_shift && (shamt != '0)) begin
                            work  <= a;
                            cnt   <= shamt;
                            state <= S_SHIFT;
                        end else begin
                            result <= alu_res;
                            state  <= S_DONE;
                            case (op)
                                OP_ADD, OP_SUB:
                                    flags <= {add_sat == '0, add_ovf, add_sat[WIDTH-1]};
                                OP_XOR, OP_SLL, OP_SRA, OP_ROR:
                                    flags[2] <= (alu_res == '0);
                                default: ;
                            endcase
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
